// File: rtl/char_t.sv
// UART transmitter: serializes 8-bit characters as 8N1 frames at one of four
// selectable bit periods, with a one-entry holding register for back-to-back frames.
module char_t #(
  parameter logic [15:0] PERIOD0 = 16'd10,
  parameter logic [15:0] PERIOD1 = 16'd20,
  parameter logic [15:0] PERIOD2 = 16'd40,
  parameter logic [15:0] PERIOD3 = 16'd80
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_baud,
  input  logic [7:0] i_char,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_finished
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [15:0] div_cnt, div_next;
  logic [2:0]  bit_cnt, bit_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  hold, hold_next;
  logic        hold_full, hold_full_next;
  logic [15:0] period, period_next;
  logic        finished_next;
  logic        tx_next;
  logic        transfer;
  logic        bit_end;

  function automatic logic [15:0] baud_period(input logic [1:0] sel);
    case (sel)
      2'd0:    baud_period = PERIOD0;
      2'd1:    baud_period = PERIOD1;
      2'd2:    baud_period = PERIOD2;
      default: baud_period = PERIOD3;
    endcase
  endfunction

  assign transfer = i_valid && !hold_full;
  assign bit_end  = (div_cnt == (period - 16'd1));
  assign o_ready  = !hold_full;
  assign o_busy   = (state != IDLE);

  always_comb begin
    state_next     = state;
    div_next       = div_cnt;
    bit_next       = bit_cnt;
    shift_next     = shift;
    hold_next      = hold;
    hold_full_next = hold_full;
    period_next    = period;
    finished_next  = 1'b0;
    tx_next        = 1'b1;

    case (state)
      IDLE: begin
        div_next = 16'd0;
        if (transfer) begin
          shift_next  = i_char;
          period_next = baud_period(i_baud);
          bit_next    = 3'd0;
          state_next  = START;
        end
      end
      START: begin
        if (bit_end) begin
          div_next   = 16'd0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          div_next = div_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          div_next   = 16'd0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_next   = 3'd0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          div_next = div_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          finished_next = 1'b1;
          div_next      = 16'd0;
          bit_next      = 3'd0;
          // A held character takes priority; otherwise a fresh transfer can chain directly.
          if (hold_full) begin
            shift_next     = hold;
            hold_full_next = 1'b0;
            period_next    = baud_period(i_baud);
            state_next     = START;
          end else if (transfer) begin
            shift_next  = i_char;
            period_next = baud_period(i_baud);
            state_next  = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          div_next = div_cnt + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        div_next   = 16'd0;
        bit_next   = 3'd0;
      end
    endcase

    if (transfer && (state != IDLE) && !((state == STOP) && bit_end)) begin
      hold_next      = i_char;
      hold_full_next = 1'b1;
    end

    // The line level is computed from next state so the pin comes straight off a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      div_cnt    <= 16'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      hold       <= 8'd0;
      hold_full  <= 1'b0;
      period     <= PERIOD0;
      o_finished <= 1'b0;
      o_tx       <= 1'b1;
    end else begin
      state      <= state_next;
      div_cnt    <= div_next;
      bit_cnt    <= bit_next;
      shift      <= shift_next;
      hold       <= hold_next;
      hold_full  <= hold_full_next;
      period     <= period_next;
      o_finished <= finished_next;
      o_tx       <= tx_next;
    end
  end

endmodule

// File: tb/tb_char_t.sv
// Self-checking bench for char_t: directed frames checked cycle by cycle against
// a small 8N1 line model, plus reset, chaining and backpressure scenarios.
module tb_char_t;

  logic       i_clk;
  logic       i_rst;
  logic [1:0] i_baud;
  logic [7:0] i_char;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_finished;

  int pass_count  = 0;
  int check_count = 0;

  char_t dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_baud     (i_baud),
    .i_char     (i_char),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_finished (o_finished)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected line level c cycles after the accepting edge of a frame.
  function automatic logic exp_tx(input logic [7:0] ch, input int p, input int c);
    int b;
    b = c / p;
    if (b == 0) return 1'b0;
    if (b >= 9) return 1'b1;
    return ch[b-1];
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_char = 8'h00; i_baud = 2'd0;
    #2;
    check_count++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_finished !== 1'b0)
      $display("[TB] FAIL reset_values: tx=%b ready=%b busy=%b fin=%b, required 1 1 0 0",
               o_tx, o_ready, o_busy, o_finished);
    else pass_count++;
    tick(); tick();
    i_rst = 1'b0;
    tick(); tick();
    check_count++;
    if (o_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_finished !== 1'b0)
      $display("[TB] FAIL idle_after_reset: tx=%b ready=%b busy=%b fin=%b, required 1 1 0 0",
               o_tx, o_ready, o_busy, o_finished);
    else pass_count++;
  endtask

  task automatic test_single_byte();
    i_baud = 2'd0; i_char = 8'hA5; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'hA5, 10, c) || o_busy !== 1'b1 || o_finished !== 1'b0)
        $display("[TB] FAIL single_frame c=%0d: tx=%b busy=%b fin=%b, required tx=%b busy=1 fin=0",
                 c, o_tx, o_busy, o_finished, exp_tx(8'hA5, 10, c));
      else pass_count++;
      tick();
    end
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1)
      $display("[TB] FAIL single_end: fin=%b busy=%b tx=%b, required 1 0 1", o_finished, o_busy, o_tx);
    else pass_count++;
    tick();
    check_count++;
    if (o_finished !== 1'b0)
      $display("[TB] FAIL single_pulse_width: fin=%b, required 0", o_finished);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    i_baud = 2'd0; i_char = 8'h00; i_valid = 1'b1;
    tick();
    for (int c = 0; c < 100; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'h00, 10, c) || o_ready !== (c == 0) || o_finished !== 1'b0)
        $display("[TB] FAIL b2b_first c=%0d: tx=%b ready=%b fin=%b, required tx=%b ready=%b fin=0",
                 c, o_tx, o_ready, o_finished, exp_tx(8'h00, 10, c), (c == 0));
      else pass_count++;
      if (c == 0) i_char = 8'hFF;
      if (c == 1) i_valid = 1'b0;
      tick();
    end
    for (int c = 0; c < 100; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'hFF, 10, c) || o_finished !== (c == 0) || o_busy !== 1'b1 || o_ready !== 1'b1)
        $display("[TB] FAIL b2b_second c=%0d: tx=%b fin=%b busy=%b ready=%b, required tx=%b fin=%b busy=1 ready=1",
                 c, o_tx, o_finished, o_busy, o_ready, exp_tx(8'hFF, 10, c), (c == 0));
      else pass_count++;
      tick();
    end
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0)
      $display("[TB] FAIL b2b_end: fin=%b busy=%b, required 1 0", o_finished, o_busy);
    else pass_count++;
    tick();
  endtask

  task automatic test_baud_change();
    i_baud = 2'd1; i_char = 8'h55; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'h55, 20, c) || o_busy !== 1'b1)
        $display("[TB] FAIL baud_hold c=%0d: tx=%b busy=%b, required tx=%b busy=1",
                 c, o_tx, o_busy, exp_tx(8'h55, 20, c));
      else pass_count++;
      if (c == 49) i_baud = 2'd3;
      tick();
    end
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0)
      $display("[TB] FAIL baud_hold_end: fin=%b busy=%b, required 1 0", o_finished, o_busy);
    else pass_count++;
    i_char = 8'hC3; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'hC3, 80, c) || o_finished !== 1'b0)
        $display("[TB] FAIL baud_new c=%0d: tx=%b fin=%b, required tx=%b fin=0",
                 c, o_tx, o_finished, exp_tx(8'hC3, 80, c));
      else pass_count++;
      tick();
    end
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0)
      $display("[TB] FAIL baud_new_end: fin=%b busy=%b, required 1 0", o_finished, o_busy);
    else pass_count++;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    i_baud = 2'd0; i_char = 8'h12; i_valid = 1'b1;
    tick();
    i_char = 8'h34;
    tick();
    i_valid = 1'b0;
    for (int c = 1; c < 34; c++) tick();
    check_count++;
    if (o_tx !== 1'b0 || o_ready !== 1'b0)
      $display("[TB] FAIL pre_abort: tx=%b ready=%b, required 0 0", o_tx, o_ready);
    else pass_count++;
    i_rst = 1'b1;
    #1;
    check_count++;
    if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_finished !== 1'b0)
      $display("[TB] FAIL abort_async: tx=%b busy=%b ready=%b fin=%b, required 1 0 1 0",
               o_tx, o_busy, o_ready, o_finished);
    else pass_count++;
    tick(); tick();
    i_rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      check_count++;
      if (o_tx !== 1'b1 || o_finished !== 1'b0 || o_busy !== 1'b0)
        $display("[TB] FAIL abort_quiet c=%0d: tx=%b fin=%b busy=%b, required 1 0 0",
                 c, o_tx, o_finished, o_busy);
      else pass_count++;
      tick();
    end
    i_char = 8'h3C; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      check_count++;
      if (o_tx !== exp_tx(8'h3C, 10, c))
        $display("[TB] FAIL after_abort c=%0d: tx=%b, required %b", c, o_tx, exp_tx(8'h3C, 10, c));
      else pass_count++;
      tick();
    end
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0)
      $display("[TB] FAIL after_abort_end: fin=%b busy=%b, required 1 0", o_finished, o_busy);
    else pass_count++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [3];
    int         accept_edge [3];
    int         idx;
    logic       ready_before;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    accept_edge[0] = 0; accept_edge[1] = -1; accept_edge[2] = -1;
    i_baud = 2'd2; i_char = bytes[0]; i_valid = 1'b1;
    tick();
    idx = 1;
    for (int c = 0; c < 1200; c++) begin
      check_count++;
      if (o_tx !== exp_tx(bytes[c/400], 40, c % 400) || o_finished !== (c == 400 || c == 800) || o_busy !== 1'b1)
        $display("[TB] FAIL bp_line c=%0d: tx=%b fin=%b busy=%b, required tx=%b fin=%b busy=1",
                 c, o_tx, o_finished, o_busy, exp_tx(bytes[c/400], 40, c % 400), (c == 400 || c == 800));
      else pass_count++;
      if (c >= 1 && c < 400) begin
        check_count++;
        if (o_ready !== 1'b0)
          $display("[TB] FAIL bp_ready c=%0d: ready=%b, required 0", c, o_ready);
        else pass_count++;
      end
      if (idx < 3) begin
        i_valid = 1'b1;
        i_char  = bytes[idx];
      end else begin
        i_valid = 1'b0;
      end
      ready_before = o_ready;
      tick();
      if (i_valid && ready_before) begin
        accept_edge[idx] = c + 1;
        idx++;
      end
    end
    i_valid = 1'b0;
    check_count++;
    if (accept_edge[1] !== 1 || accept_edge[2] !== 401)
      $display("[TB] FAIL bp_accept: edges %0d,%0d, required 1,401", accept_edge[1], accept_edge[2]);
    else pass_count++;
    check_count++;
    if (o_finished !== 1'b1 || o_busy !== 1'b0 || o_tx !== 1'b1)
      $display("[TB] FAIL bp_end: fin=%b busy=%b tx=%b, required 1 0 1", o_finished, o_busy, o_tx);
    else pass_count++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_baud_change();
    test_reset_mid_frame();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/char_t.md
# char_t

UART transmitter, the counterpart to the team's character receiver. It serializes 8-bit characters onto a single TX line as 8N1 frames (start bit, 8 data bits LSB first, stop bit) at one of four selectable bit periods. Characters arrive through a valid/ready handshake. A one-entry holding register allows back-to-back frames with no idle gap. The block sits between the host-side character source and the board TX pin.

## Interface
- PERIOD0, 10, clocks per bit when i_baud=0 (16-bit value, must be ≥2)
- PERIOD1, 20, clocks per bit when i_baud=1
- PERIOD2, 40, clocks per bit when i_baud=2
- PERIOD3, 80, clocks per bit when i_baud=3
- i_clk  input  1  sole clock; all logic on posedge
- i_rst  input  1  reset, asynchronous, active-high
- i_baud  input  2  bit-period select, sampled only when a frame starts
- i_char  input  8  character to send
- i_valid  input  1  i_char is valid
- o_ready  output  1  block can accept a character this cycle
- o_tx  output  1  serial line; idles high
- o_busy  output  1  frame in progress (state ≠ IDLE)
- o_finished  output  1  one-cycle pulse after each frame's stop bit completes

## Operation
- **Transfer.** A transfer occurs on a posedge where i_valid && o_ready. o_ready = !hold_full, which is combinational from a register.
- **Acceptance in IDLE.** The character loads directly into the shift register and the state goes to START. The holding register stays empty, so o_ready stays 1.
- **Acceptance during a frame.** The character loads into the holding register, and o_ready drops to 0 the next cycle.
- **States.**
  - IDLE: o_tx=1.
  - START: o_tx=0 for P cycles.
  - DATA: o_tx=shift[0] for P cycles per bit. Shift right after each bit. A 3-bit counter runs 0..7; leave DATA after bit 7.
  - STOP: o_tx=1 for P cycles.
- **End of STOP, selecting the next frame.**
  - If the holding register is full: move it to the shift register, clear hold_full, and go to START.
  - Else, if a transfer occurs on that same edge: that character goes to START.
  - Otherwise: go to IDLE.
- **Bit period.** P is latched from i_baud whenever the shift register is loaded. Changes to i_baud mid-frame are ignored.
- **Divider.** 16-bit, counts 0..P-1. The bit boundary is at count P-1, after which the count wraps to 0. It is reset to 0 at every frame start.
- **o_tx source.** o_tx is driven from registered state only, so it is glitch-free.

## Timing
- Counting the accepting posedge as edge 0:
  - o_tx is low from edge 0 to edge P.
  - Data bit i is driven from edge P·(i+1) to edge P·(i+2).
  - The stop bit runs from edge 9P to edge 10P.
  - o_finished is high from edge 10P to edge 10P+1.
- Frame length is exactly 10·P cycles.
- Back-to-back frames: the next start bit begins at edge 10P, the same edge as the o_finished pulse. There are zero idle cycles.
- o_ready returns to 1 at the edge where the held character moves to the shift register.
- o_busy is 1 from edge 0 through the last STOP cycle. It is 0 at edge 10P only if no next frame starts.
- Reset values, applied immediately while i_rst=1 and independent of the clock: o_tx=1, o_ready=1, o_busy=0, o_finished=0. Also state=IDLE, hold_full=0, and counters=0.
- Reset mid-frame: o_tx returns high immediately and the held character is discarded. No o_finished pulse is produced for the aborted frame.
- i_valid with o_ready=0: no transfer. i_char and i_valid may be held without effect until o_ready=1.

## Test plan
- **Single byte.** Reset, i_baud=0, send 0xA5. o_tx is low for edges 0–10, then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high for edges 90–100. o_finished pulses at edge 100. o_busy is 0 at edge 100.
- **Back-to-back.** Hold i_valid with 0x00 then 0xFF at i_baud=0. The second byte is accepted at edge 1. o_ready is 0 from edge 1 to edge 100. The second start bit begins at edge 100, with no high gap. o_finished pulses at edges 100 and 200.
- **Baud change mid-frame.** Send 0x55 with i_baud=1, then set i_baud=3 at edge 50. The frame still spans 200 cycles with 20-cycle bits. The next frame uses 80-cycle bits.
- **Reset mid-frame.** At i_baud=0, send 0x12, queue 0x34, and assert i_rst at edge 35 for 2 cycles. o_tx=1 and o_busy=0 immediately. 0x34 is never sent and no o_finished pulse occurs. A subsequent 0x3C is sent normally.
- **Backpressure ordering.** Offer 0x01, 0x02, 0x03 continuously at i_baud=2. 0x03 waits with o_ready=0 until edge 400. Bytes are sent in order in 1200 contiguous cycles, with three o_finished pulses at edges 400, 800 and 1200.
